// File: rtl/mdu_ctrl_pkg.sv
// Shared opcode and state encodings for the multiply/divide unit controller.
// Also holds a small helper that takes the magnitude of a signed operand.
package mdu_ctrl_pkg;

    localparam int MDU_OP_WD = 3;

    typedef enum logic [MDU_OP_WD-1:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic isSigned);
        return (isSigned && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// EXE-stage <-> MDU handshake bundle: operation issue, ack, ready and HI/LO readback.
interface mdu_ctrl_if;
    import mdu_ctrl_pkg::*;

    logic                 op_valid;
    logic [MDU_OP_WD-1:0] op_code;
    logic [31:0]          src1;
    logic [31:0]          src2;
    logic                 op_ack;
    logic                 op_ready;
    logic                 busy;
    logic [31:0]          hi;
    logic [31:0]          lo;

    modport master (
        output op_valid, op_code, src1, src2, op_ack,
        input  op_ready, busy, hi, lo
    );

    modport slave (
        input  op_valid, op_code, src1, src2, op_ack,
        output op_ready, busy, hi, lo
    );
endinterface

// File: rtl/mdu_ctrl_div_iter.sv
// Iterative restoring divider: one shift-subtract step per cycle plus sign pre/post-processing.
// The final step and sign fix are combinational so the result commits on the step-32 edge.
module mdu_ctrl_div_iter
    import mdu_ctrl_pkg::*;
#(
    parameter int DIV_STEPS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        run_i,
    output logic        done_o,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o
);
    localparam logic [5:0] LAST_STEP = 6'(DIV_STEPS - 1);

    logic [63:0] rem_q, rem_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] dvs_q;
    logic [31:0] rawA_q;
    logic [5:0]  cnt_q;
    logic        negQ_q, negR_q, div0_q;
    logic [32:0] partial, diff;
    logic        geq;

    // The partial remainder can reach 33 bits when the divisor exceeds 2^31.
    always_comb begin
        partial = rem_q[63:31];
        diff    = partial - {1'b0, dvs_q};
        geq     = ~diff[32];
        rem_d   = geq ? {diff[31:0], rem_q[30:0], 1'b0} : {rem_q[62:0], 1'b0};
        quot_d  = {quot_q[30:0], geq};
    end

    always_comb begin
        done_o = run_i && (cnt_q == LAST_STEP);
        quot_o = negQ_q ? (~quot_d + 32'd1) : quot_d;
        rem_o  = negR_q ? (~rem_d[63:32] + 32'd1) : rem_d[63:32];
        if (div0_q) begin
            quot_o = 32'hFFFF_FFFF;
            rem_o  = rawA_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvs_q  <= '0;
            rawA_q <= '0;
            cnt_q  <= '0;
            negQ_q <= 1'b0;
            negR_q <= 1'b0;
            div0_q <= 1'b0;
        end else if (start_i) begin
            rem_q  <= {32'd0, abs32(dividend_i, signed_i)};
            quot_q <= '0;
            dvs_q  <= abs32(divisor_i, signed_i);
            rawA_q <= dividend_i;
            cnt_q  <= '0;
            negQ_q <= signed_i && (dividend_i[31] ^ divisor_i[31]);
            negR_q <= signed_i && dividend_i[31];
            div0_q <= (divisor_i == 32'd0);
        end else if (run_i) begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            cnt_q  <= cnt_q + 6'd1;
        end
    end
endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller beside EXE: owns HI/LO, runs MULT/MULTU in one cycle and DIV/DIVU via the iterative divider.
// EXE is held until op_ready; DONE waits for op_ack before accepting the next operation.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int DIV_STEPS = 32
) (
    input  logic      clk,
    input  logic      reset,
    mdu_ctrl_if.slave bus
);
    mdu_state_e  state_q, state_d;
    logic [31:0] hi_q, lo_q;
    logic [32:0] mulA_q, mulB_q;
    logic [63:0] product;
    logic        isMul, isDiv, isMthi, isMtlo;
    logic        issue, mulStart, divStart, divRun, mulWrite;
    logic        divDone;
    logic [31:0] divQuot, divRem;

    always_comb begin
        isMul  = (bus.op_code == OP_MULT) || (bus.op_code == OP_MULTU);
        isDiv  = (bus.op_code == OP_DIV)  || (bus.op_code == OP_DIVU);
        isMthi = (bus.op_code == OP_MTHI);
        isMtlo = (bus.op_code == OP_MTLO);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Dropping op_valid mid-operation means EXE was flushed, so the operation is abandoned.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.op_valid && isMul)      state_d = ST_MUL;
                else if (bus.op_valid && isDiv) state_d = ST_DIV;
            end
            ST_MUL:  state_d = bus.op_valid ? ST_DONE : ST_IDLE;
            ST_DIV: begin
                if (!bus.op_valid) state_d = ST_IDLE;
                else if (divDone)  state_d = ST_DONE;
            end
            ST_DONE: if (bus.op_ack) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        issue        = (state_q == ST_IDLE) && bus.op_valid;
        mulStart     = issue && isMul;
        divStart     = issue && isDiv;
        divRun       = (state_q == ST_DIV) && bus.op_valid;
        mulWrite     = (state_q == ST_MUL) && bus.op_valid;
        bus.op_ready = (state_q == ST_DONE) || (issue && !isMul && !isDiv);
        bus.busy     = (state_q != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mulA_q <= '0;
            mulB_q <= '0;
        end else if (mulStart) begin
            mulA_q <= {(bus.op_code == OP_MULT) && bus.src1[31], bus.src1};
            mulB_q <= {(bus.op_code == OP_MULT) && bus.src2[31], bus.src2};
        end
    end

    // The low 64 bits of the extended product are correct for both signed and unsigned operands.
    assign product = {{31{mulA_q[32]}}, mulA_q} * {{31{mulB_q[32]}}, mulB_q};

    mdu_ctrl_div_iter #(
        .DIV_STEPS (DIV_STEPS)
    ) u_div (
        .clk        (clk),
        .reset      (reset),
        .start_i    (divStart),
        .signed_i   (bus.op_code == OP_DIV),
        .dividend_i (bus.src1),
        .divisor_i  (bus.src2),
        .run_i      (divRun),
        .done_o     (divDone),
        .quot_o     (divQuot),
        .rem_o      (divRem)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (mulWrite) begin
            {hi_q, lo_q} <= product;
        end else if (divDone) begin
            hi_q <= divRem;
            lo_q <= divQuot;
        end else if (issue && isMthi) begin
            hi_q <= bus.src1;
        end else if (issue && isMtlo) begin
            lo_q <= bus.src1;
        end
    end

    assign bus.hi = hi_q;
    assign bus.lo = lo_q;
endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

- Multiply/divide unit controller for the five-stage MIPS pipeline.
- Sits beside the EXE stage and executes MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Owns the architectural HI/LO registers and sequences a 32-step iterative divider.
- Holds EXE via `op_ready` until a result is committed and the stage has advanced.

## Interface
Parameters:
- `DIV_STEPS`, 32: divider iterations; only 32 is supported.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `op_valid` in 1: EXE holds a valid MDU instruction.
- `op_code` in 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 ignored.
- `src1` in 32: rs value, already forwarded.
- `src2` in 32: rt value, already forwarded.
- `op_ack` in 1: EXE instruction leaves the stage this cycle (`es_to_ms_valid && ms_allowin`).
- `op_ready` out 1: operation committed; EXE uses `es_ready_go = !mdu_inst || op_ready`.
- `busy` out 1: state is not IDLE.
- `hi` out 32: architectural HI, read by MFHI.
- `lo` out 32: architectural LO, read by MFLO.

## Operation
- States:
  - IDLE
  - MUL
  - DIV
  - DONE
- Reset (async): state=IDLE, `hi`=`lo`=0, divider regs 0, `op_ready`=0, `busy`=0.
- IDLE, MTHI/MTLO: `op_ready`=1 combinationally. `hi` (or `lo`) ← `src1` at the clock edge. State stays IDLE; rewriting while `op_ack`=0 is idempotent.
- IDLE, MULT/MULTU: latch operands → MUL. MUL computes the 64-bit product, signed or unsigned per op. {`hi`,`lo`} ← product → DONE.
- IDLE, DIV/DIVU: latch |src1|, |src2| (raw values for DIVU) and sign flags → DIV.
  - 32 restoring shift-subtract steps on a 64-bit remainder register and 32-bit quotient, one step per cycle, with a step counter.
  - After step 32, apply sign fix: quotient negated if operand signs differ, remainder takes the dividend's sign.
  - `lo` ← quotient, `hi` ← remainder → DONE.
- DONE: `op_ready`=1. Stay until `op_ack`=1, then → IDLE. HI/LO are not rewritten while waiting.
- Cancel: `op_valid`=0 while in MUL or DIV → IDLE next cycle, HI/LO untouched.
- Divide by zero (either signedness): `lo`=0xFFFFFFFF, `hi`=`src1`, normal latency, no exception.
- DIV 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
- op_code 6–7 with `op_valid`: treated as no-op; `op_ready`=1, no state change.
- `hi`/`lo` outputs are the registers directly, so MFHI in EXE reads the value committed by any earlier MDU op.
- The MEM/WB forwarding paths are not involved.

## Timing
- Issue cycle = the IDLE cycle with `op_valid`=1 (cycle 0).
- MTHI/MTLO: `op_ready` in cycle 0; HI/LO visible in cycle 1.
- MULT/MULTU: MUL in cycle 1; DONE and `op_ready` from cycle 2; HI/LO visible in cycle 2.
- DIV/DIVU: DIV in cycles 1–32; DONE and `op_ready` from cycle 33; HI/LO visible in cycle 33.
- `op_ready` in DONE is registered-state decoded (glitch-free). Only the IDLE MTHI/MTLO path is combinational.
- A back-to-back MDU op may issue in the cycle after DONE+`op_ack`; there is no bubble inside the block.
- `busy` is high in MUL, DIV and DONE.
- Reset asserted mid-divide: the block is in IDLE with HI/LO=0 immediately, without waiting for a clock edge.

## Structure
- `mycpu.h`: `MDU_OP_WD` (3) and `MDU_MULT`..`MDU_MTLO` code defines, plus state encodings.
- The ID stage extends `ds_to_es_bus` with `mdu_op` and a `mdu_valid` bit.
- Sub-module `div_iter`: step counter, remainder/quotient registers, start/done handshake, sign pre/post-processing.
- `mdu_ctrl` owns the FSM, the multiplier (`*` on 33-bit sign/zero-extended operands), the HI/LO registers and the ready/ack logic.

## Test plan
- Write and read back:
  - MTHI 0x12345678 → `op_ready` same cycle, `hi`=0x12345678 next cycle.
  - Then MTLO 0xCAFEF00D → `lo`=0xCAFEF00D, `hi` unchanged.
- Multiply:
  - MULT 0xFFFFFFFE × 0x00000003 → cycle 2 `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA.
  - MULTU same operands → `hi`=0x00000002, `lo`=0xFFFFFFFA.
- Divide:
  - DIV 0xFFFFFFF9 (−7) / 2 → `op_ready` exactly at cycle 33, `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIVU 100/7 → `lo`=14, `hi`=2.
- Corner cases:
  - DIVU 5/0 → `lo`=0xFFFFFFFF, `hi`=5.
  - DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Backpressure and back-to-back:
  - DIV completes with `op_ack` held 0 for 5 cycles → DONE held, `op_ready`=1 throughout, HI/LO stable.
  - `op_ack` pulse → IDLE; an immediate MULTU issues the next cycle.
- Cancel and reset:
  - `op_valid` dropped at DIV cycle 10 → IDLE next cycle, HI/LO unchanged.
  - `reset` pulsed asynchronously at DIV cycle 20 → IDLE, `hi`=`lo`=0, `busy`=0 before the next edge.
